// File: rtl/fp_norm_pkg.sv
// Shared types and format helpers for the post-arithmetic normalizer.
package fp_norm_pkg;

  // Supported floating-point target formats.
  typedef enum logic [1:0] {
    FP16,
    FP32,
    FP64
  } fp_format_e;

  // Normalizer control states.
  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } norm_state_e;

  // Exponent field width of a format.
  function automatic int unsigned exp_bits(fp_format_e fmt);
    case (fmt)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  // Stored mantissa width of a format (hidden bit excluded).
  function automatic int unsigned mant_bits(fp_format_e fmt);
    case (fmt)
      FP16:    return 10;
      FP64:    return 52;
      default: return 23;
    endcase
  endfunction

  // Total packed width of a format.
  function automatic int unsigned fp_width(fp_format_e fmt);
    return 1 + exp_bits(fmt) + mant_bits(fmt);
  endfunction

  // Width of the packed unrounded result: encoding + rs(2) + round_en + invalid + exp_cout(2).
  function automatic int unsigned ures_width(fp_format_e fmt);
    return fp_width(fmt) + 6;
  endfunction

endpackage

// File: rtl/fp_lzc_step.sv
// Leading-zero count over a small window, saturated to the window size.
module fp_lzc_step #(
  parameter int unsigned STEP = 4
) (
  input  logic [STEP-1:0]            bits,
  output logic [$clog2(STEP+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(STEP + 1);

  // Scan from LSB upward so the highest set bit decides the count last.
  always_comb begin
    // NOTE: a default before any conditional write keeps combinational logic latch-free.
    count = CW'(STEP);
    for (int i = 0; i < int'(STEP); i++) begin
      if (bits[i]) count = CW'(int'(STEP) - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm.sv
// Sequential normalizer: aligns the hidden bit, gathers sticky and packs
// the unrounded result for the rounding stage. One transaction in flight.
module fp_norm
  import fp_norm_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT  = FP32,
  parameter int unsigned IN_WIDTH   = 2 * (mant_bits(FP_FORMAT) + 1),
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic                                sign_i,
  input  logic [exp_bits(FP_FORMAT)+1:0]      exp_i,
  input  logic [IN_WIDTH-1:0]                 mant_i,
  input  logic                                sticky_i,
  input  logic                                special_i,
  input  logic [fp_width(FP_FORMAT)-1:0]      special_result_i,
  input  logic                                invalid_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [ures_width(FP_FORMAT)-1:0]    urnd_result_o
);

  localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT);
  localparam int unsigned MANT_WIDTH = mant_bits(FP_FORMAT);
  localparam int unsigned EW         = EXP_WIDTH + 2;
  // The lookahead window sits below bit IN_WIDTH-1, so it can never exceed IN_WIDTH-1 bits.
  localparam int unsigned STEP       = (SHIFT_STEP < IN_WIDTH - 1) ? SHIFT_STEP : IN_WIDTH - 1;
  localparam int unsigned CW         = $clog2(STEP + 1);

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
  } fp_encoding_t;

  typedef struct packed {
    fp_encoding_t u_result;
    logic [1:0]   rs;
    logic         round_en;
    logic         invalid;
    logic [1:0]   exp_cout;
  } uround_res_t;

  norm_state_e         state_q, state_d;
  logic                sign_q;
  logic [EW-1:0]       exp_q;
  logic [IN_WIDTH-1:0] mant_q;
  logic                stk_q;
  logic                inv_q;
  uround_res_t         res_q;

  logic [CW-1:0]       shift_amt;
  logic [IN_WIDTH-1:0] fix_mant;
  logic [EW-1:0]       fix_exp;
  logic                fix_stk;
  uround_res_t         norm_res;
  uround_res_t         bypass_res;

  logic top_set, hidden_set;
  assign top_set    = mant_q[IN_WIDTH-1];
  assign hidden_set = mant_q[IN_WIDTH-2];

  fp_lzc_step #(
    .STEP (STEP)
  ) u_lzc (
    .bits  (mant_q[IN_WIDTH-2 -: STEP]),
    .count (shift_amt)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (valid_i) state_d = (special_i || mant_i == '0) ? DONE : NORM;
      NORM: if (top_set || hidden_set) state_d = DONE;
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
  end

  // Final alignment (carry-out right shift) and packing of the working value.
  always_comb begin
    fix_mant = mant_q;
    fix_exp  = exp_q;
    fix_stk  = stk_q;
    if (top_set) begin
      fix_mant = mant_q >> 1;
      fix_stk  = stk_q | mant_q[0];
      fix_exp  = exp_q + EW'(1);
    end
    norm_res               = '0;
    norm_res.u_result.sign = sign_q;
    norm_res.u_result.exp  = fix_exp[EXP_WIDTH-1:0];
    norm_res.u_result.mant = fix_mant[IN_WIDTH-3 -: MANT_WIDTH];
    norm_res.rs            = {fix_mant[IN_WIDTH-3-MANT_WIDTH],
                              (|fix_mant[IN_WIDTH-4-MANT_WIDTH:0]) | fix_stk};
    norm_res.round_en      = 1'b1;
    norm_res.invalid       = inv_q;
    norm_res.exp_cout      = fix_exp[EW-1 -: 2];
  end

  // Result for inputs that skip normalization: precomputed special or signed zero.
  always_comb begin
    bypass_res         = '0;
    bypass_res.invalid = invalid_i;
    if (special_i) bypass_res.u_result      = special_result_i;
    else           bypass_res.u_result.sign = sign_i;
  end

  // Datapath: latch operands, shift toward the hidden bit, register the packed result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: every datapath register is reset so no stale result survives an abort.
    if (!rst_ni) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      stk_q  <= 1'b0;
      inv_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            inv_q <= invalid_i;
            if (special_i || mant_i == '0) begin
              res_q <= bypass_res;
            end else begin
              sign_q <= sign_i;
              exp_q  <= exp_i;
              mant_q <= mant_i;
              stk_q  <= sticky_i;
            end
          end
        end
        NORM: begin
          if (top_set || hidden_set) begin
            res_q <= norm_res;
          end else begin
            mant_q <= mant_q << shift_amt;
            exp_q  <= exp_q - EW'(shift_amt);
          end
        end
        default: ;
      endcase
    end
  end

  assign urnd_result_o = res_q;

endmodule

// File: tb/tb_fp_norm.sv
// Self-checking bench for fp_norm (FP32, IN_WIDTH=48, SHIFT_STEP=4).
module tb_fp_norm;
  import fp_norm_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [9:0]  exp_i;
  logic [47:0] mant_i;
  logic        sticky_i;
  logic        special_i;
  logic [31:0] special_result_i;
  logic        invalid_i;
  logic        valid_o;
  logic        ready_i;
  logic [37:0] urnd_result_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [37:0] exp_res = '0;

  always #5 clk_i = ~clk_i;

  fp_norm #(
    .FP_FORMAT  (FP32),
    .IN_WIDTH   (48),
    .SHIFT_STEP (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .sign_i           (sign_i),
    .exp_i            (exp_i),
    .mant_i           (mant_i),
    .sticky_i         (sticky_i),
    .special_i        (special_i),
    .special_result_i (special_result_i),
    .invalid_i        (invalid_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .urnd_result_o    (urnd_result_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: locate the leading one, align it to bit 46 in one step, then pack.
  function automatic void model(input logic s, input logic [9:0] e_in, input logic [47:0] m_in,
                                input logic stk_in, input logic spc, input logic [31:0] sres,
                                input logic inv, output logic [37:0] res, output int lat);
    logic [47:0] m;
    logic [9:0]  e;
    logic        stk;
    int          p;
    int          l;
    if (spc) begin
      res = {sres, 2'b00, 1'b0, inv, 2'b00};
      lat = 1;
    end else if (m_in == '0) begin
      res = {s, 31'd0, 2'b00, 1'b0, inv, 2'b00};
      lat = 1;
    end else begin
      p = 0;
      for (int i = 0; i < 48; i++) if (m_in[i]) p = i;
      m   = m_in;
      e   = e_in;
      stk = stk_in;
      if (p == 47) begin
        stk = stk | m[0];
        m   = m >> 1;
        e   = e + 10'd1;
        lat = 2;
      end else begin
        l   = 46 - p;
        m   = m << l;
        e   = e - 10'(l);
        lat = 2 + (l + 3) / 4;
      end
      res = {s, e[7:0], m[45:23], m[22], (|m[21:0]) | stk, 1'b1, inv, e[9:8]};
    end
  endfunction

  // Every cycle the output is valid it must equal the model's prediction and block new input.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o) begin
      check("mon_result", urnd_result_o, exp_res);
      check("mon_ready_low", ready_o, 1'b0);
    end
  end

  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m, input logic stk,
                       input logic spc, input logic [31:0] sres, input logic inv);
    sign_i           = s;
    exp_i            = e;
    mant_i           = m;
    sticky_i         = stk;
    special_i        = spc;
    special_result_i = sres;
    invalid_i        = inv;
  endtask

  // Issue one transaction and wait (bounded) for valid_o; checks latency and result.
  task automatic run(input string name, input logic s, input logic [9:0] e, input logic [47:0] m,
                     input logic stk, input logic spc, input logic [31:0] sres, input logic inv);
    int n;
    int lat;
    n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    check({name, "_ready_in"}, ready_o, 1'b1);
    model(s, e, m, stk, spc, sres, inv, exp_res, lat);
    drive(s, e, m, stk, spc, sres, inv);
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    n = 1;
    while (!valid_o && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    check({name, "_latency"}, n, lat);
    check({name, "_result"}, urnd_result_o, exp_res);
  endtask

  // Let DONE hand off and confirm the block is idle again.
  task automatic release_done(input string name);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    check({name, "_idle_ready"}, ready_o, 1'b1);
    check({name, "_idle_valid"}, valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        stale;
    logic [47:0] rm;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_valid", valid_o, 1'b0);
    check("reset_ready", ready_o, 1'b1);
    check("reset_result", urnd_result_o, 38'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Already normalized: 1.0 * 2^0.
    run("norm", 1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, '0, 1'b0);
    check("norm_u_result", urnd_result_o[37:6], 32'h3F80_0000);
    check("norm_rs", urnd_result_o[5:4], 2'b00);
    check("norm_round_en", urnd_result_o[3], 1'b1);
    check("norm_cout", urnd_result_o[1:0], 2'b00);
    release_done("norm");

    // Carry-out: right shift, LSB goes to sticky.
    run("carry", 1'b0, 10'd127, 48'h8000_0000_0001, 1'b0, 1'b0, '0, 1'b0);
    check("carry_u_result", urnd_result_o[37:6], 32'h4000_0000);
    check("carry_rs", urnd_result_o[5:4], 2'b01);
    release_done("carry");

    // Left shift by 5 across two NORM steps.
    run("lshift5", 1'b0, 10'd10, 48'h0200_0000_0000, 1'b0, 1'b0, '0, 1'b0);
    check("lshift5_u_result", urnd_result_o[37:6], 32'h0280_0000);
    release_done("lshift5");

    // Left shift by 23 driving the exponent negative.
    run("lshift23", 1'b0, 10'd3, 48'h0000_0080_0000, 1'b0, 1'b0, '0, 1'b0);
    check("lshift23_exp", urnd_result_o[36:29], 8'hEC);
    check("lshift23_cout", urnd_result_o[1:0], 2'b11);
    release_done("lshift23");

    // Special bypass.
    run("special", 1'b0, 10'd0, 48'h1234_5678_9ABC, 1'b1, 1'b1, 32'h7FC0_0000, 1'b1);
    check("special_u_result", urnd_result_o[37:6], 32'h7FC0_0000);
    check("special_round_en", urnd_result_o[3], 1'b0);
    check("special_invalid", urnd_result_o[2], 1'b1);
    release_done("special");

    // Signed zero; sticky input must be ignored.
    run("zero", 1'b1, 10'd55, 48'h0, 1'b1, 1'b0, '0, 1'b0);
    check("zero_u_result", urnd_result_o[37:6], 32'h8000_0000);
    check("zero_round_en", urnd_result_o[3], 1'b0);
    check("zero_rs", urnd_result_o[5:4], 2'b00);
    release_done("zero");

    // Round/sticky bits and sign with an odd leading-zero count.
    run("rs_mix", 1'b1, 10'd100, 48'h1555_5555_5555, 1'b0, 1'b0, '0, 1'b1);
    release_done("rs_mix");

    // Backpressure: hold DONE for five cycles while junk is offered on the input.
    ready_i = 1'b0;
    run("bp", 1'b0, 10'd60, 48'h0030_0000_0F00, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10'd1, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
      valid_i = 1'b1;
      @(posedge clk_i); #1;
      check("bp_hold_valid", valid_o, 1'b1);
      check("bp_hold_ready", ready_o, 1'b0);
      check("bp_hold_result", urnd_result_o, exp_res);
    end
    valid_i = 1'b0;
    release_done("bp");

    // Reset during NORM aborts the transaction immediately.
    drive(1'b0, 10'd3, 48'h0000_0080_0000, 1'b0, 1'b0, '0, 1'b0);
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("abort_valid", valid_o, 1'b0);
    check("abort_ready", ready_o, 1'b1);
    check("abort_result", urnd_result_o, 38'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) stale = 1'b1;
    end
    check("abort_no_stale", stale, 1'b0);

    // Recovery plus a spread of leading-zero counts against the model.
    run("recover", 1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, '0, 1'b0);
    release_done("recover");
    for (int i = 0; i < 10; i++) begin
      rm = {$urandom, $urandom} >> $urandom_range(0, 46);
      if (rm == '0) rm = 48'h1;
      run("rand", 1'($urandom), 10'($urandom_range(60, 200)), rm, 1'($urandom), 1'b0, '0,
          1'($urandom));
      release_done("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fp_norm.md
Name: fp_norm

Overview:
- Sequential post-arithmetic normalizer. Feeds the rounding stage.
- Accepts a sign, a wide unnormalized significand with a signed biased exponent, and special-case bypass data.
- Shifts the significand until the hidden bit is in place. Accumulates sticky. Packs a Structs#(FP_FORMAT)::uround_res_t (u_result, rs, round_en, invalid, exp_cout) for the rounder.
- Valid/ready on both sides. One transaction in flight.

Parameters:
- FP_FORMAT, FP32: target format; sets FP_WIDTH, EXP_WIDTH, MANT_WIDTH via fp_pkg functions.
- IN_WIDTH, 2*(MANT_WIDTH+1): input significand width. Must be >= MANT_WIDTH+4.
- SHIFT_STEP, 4: maximum left-shift distance per NORM cycle. Range 1..IN_WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  input transaction valid.
- ready_o  output  1  block can accept input.
- sign_i  input  1  result sign.
- exp_i  input  EXP_WIDTH+2  signed biased exponent; weight of mant_i[IN_WIDTH-2].
- mant_i  input  IN_WIDTH  significand. Bit IN_WIDTH-1 has weight 2^1, bit IN_WIDTH-2 has weight 2^0.
- sticky_i  input  1  OR of bits already discarded upstream.
- special_i  input  1  bypass: result precomputed (NaN/Inf/etc).
- special_result_i  input  FP_WIDTH  packed bypass result.
- invalid_i  input  1  NV flag from the operation.
- valid_o  output  1  urnd_result_o valid.
- ready_i  input  1  downstream accepts.
- urnd_result_o  output  uround_res_t  packed unrounded result.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, valid_o=0, ready_o=1.
  - urnd_result_o = all zeros; internal registers zeroed.
  - Reset mid-operation discards the in-flight transaction.
- States: IDLE, NORM, DONE. ready_o=1 only in IDLE. valid_o=1 only in DONE.
- IDLE, valid_i=1 (accept edge):
  - special_i=1: pack u_result=special_result_i, rs=0, round_en=0, exp_cout=0, invalid=invalid_i. Go to DONE.
  - Else mant_i==0: pack signed zero {sign_i, 0, 0}, rs=0, round_en=0, exp_cout=0, invalid=invalid_i. sticky_i is ignored. Go to DONE.
  - Else: latch sign, exp, mant; stk=sticky_i. Go to NORM.
- NORM, one cycle per evaluation, priority order:
  - (a) m[IN_WIDTH-1]=1: m>>=1, stk|=m[0], exp+=1; pack; go to DONE.
  - (b) m[IN_WIDTH-2]=1: pack; go to DONE.
  - (c) Else: k = leading zeros of m[IN_WIDTH-2 -: SHIFT_STEP], saturated at SHIFT_STEP. m<<=k, exp-=k. Stay in NORM.
- Pack (registered on the transition into DONE):
  - u_result.sign=sign.
  - u_result.exp=exp[EXP_WIDTH-1:0]; exp_cout=exp[EXP_WIDTH+1:EXP_WIDTH].
  - u_result.mant=m[IN_WIDTH-3 -: MANT_WIDTH].
  - rs[1]=m[IN_WIDTH-3-MANT_WIDTH]; rs[0]=|m[IN_WIDTH-4-MANT_WIDTH:0] | stk.
  - round_en=1, invalid=invalid_i (latched).
- Exponent arithmetic: EXP_WIDTH+2-bit two's complement, no saturation. Negative or zero exponents are legal; the rounder denormalizes. The producer guarantees no wrap.
- DONE: hold urnd_result_o and valid_o stable until ready_i=1. On that edge go to IDLE. A new input can be accepted the following cycle (no overlap).
- Latency from accept edge to valid_o:
  - 1 cycle for special or zero.
  - 2 cycles for normalized input or bit IN_WIDTH-1 set.
  - 2+ceil(L/SHIFT_STEP) cycles, with L = leading zeros above the hidden position.
- Throughput: at most one transaction per latency+1 cycles.

Decomposition:
- fp_pkg: add typedef enum norm_state_e {IDLE, NORM, DONE}.
- Reuse Structs::uround_res_t and fp_encoding_t unchanged.
- Sub-module fp_lzc_step: combinational leading-zero count over SHIFT_STEP bits, output saturated to SHIFT_STEP.

Test Plan (FP32, IN_WIDTH=48, SHIFT_STEP=4):
- Normalized: mant_i=48'h4000_0000_0000, exp_i=127, sign 0 -> valid_o 2 cycles after accept; u_result=32'h3F80_0000, rs=00, exp_cout=00, round_en=1.
- Carry-out: mant_i=48'h8000_0000_0001, exp_i=127 -> exp=128, mant=0, rs=01, latency 2.
- Left shift: mant_i=48'h0200_0000_0000 (L=5), exp_i=10 -> exp=5, mant=0, latency 4. mant_i bit 23 set, exp_i=3 (L=23) -> exp field 8'hEC, exp_cout=2'b11, latency 8.
- Bypass: special_i=1, special_result_i=32'h7FC0_0000, invalid_i=1 -> latency 1, round_en=0, invalid=1. mant_i=0, sign_i=1 -> u_result=32'h8000_0000, round_en=0.
- Backpressure: ready_i low 5 cycles in DONE -> urnd_result_o stable, ready_o=0, valid_i ignored. Release -> IDLE next cycle, ready_o=1.
- Reset mid-NORM: rst_ni low during NORM -> valid_o=0 and ready_o=1 immediately. No stale output after release.
